// File: rtl/jtag_tap_core.sv
// IEEE 1149.1 TAP core: TAP controller, instruction register, BYPASS and IDCODE
// data registers, and steering of up to NUM_USER external user DR chains onto TDO.
module jtag_tap_core #(
    parameter int unsigned IR_WIDTH   = 4,
    parameter logic [31:0] IDCODE_VAL = 32'h1234_5679,
    parameter int unsigned IDCODE_OP  = 1,
    parameter int unsigned USER_BASE  = 8,
    parameter int unsigned NUM_USER   = 2
) (
    input  logic                TCK,
    input  logic                TRST,
    input  logic                TMS,
    input  logic                TDI,
    output logic                TDO,
    output logic                TDO_EN,
    output logic [3:0]          state_out,
    output logic [IR_WIDTH-1:0] ir_out,
    output logic                test_logic_reset,
    output logic                capture_dr,
    output logic                shift_dr,
    output logic                update_dr,
    output logic [NUM_USER-1:0] user_sel,
    input  logic [NUM_USER-1:0] user_tdo
);

    typedef enum logic [3:0] {
        TLR    = 4'h0, RTI    = 4'h1, SEL_DR = 4'h2, CAP_DR = 4'h3,
        SH_DR  = 4'h4, EX1_DR = 4'h5, PAU_DR = 4'h6, EX2_DR = 4'h7,
        UPD_DR = 4'h8, SEL_IR = 4'h9, CAP_IR = 4'hA, SH_IR  = 4'hB,
        EX1_IR = 4'hC, PAU_IR = 4'hD, EX2_IR = 4'hE, UPD_IR = 4'hF
    } tap_state_e;

    localparam logic [IR_WIDTH-1:0] IDCODE_IR  = IR_WIDTH'(IDCODE_OP);
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] IR_ONES    = '1;

    tap_state_e            state;
    tap_state_e            state_next;
    logic [IR_WIDTH-1:0]   ir;
    logic [IR_WIDTH-1:0]   ir_sr;
    logic                  bypass_reg;
    logic [31:0]           idcode_sr;
    logic                  sel_idcode;
    logic                  sel_user;
    logic                  sel_bypass;
    logic [NUM_USER-1:0]   user_sel_c;
    logic                  dr_tdo;

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            TLR:     state_next = TMS ? TLR    : RTI;
            RTI:     state_next = TMS ? SEL_DR : RTI;
            SEL_DR:  state_next = TMS ? SEL_IR : CAP_DR;
            CAP_DR:  state_next = TMS ? EX1_DR : SH_DR;
            SH_DR:   state_next = TMS ? EX1_DR : SH_DR;
            EX1_DR:  state_next = TMS ? UPD_DR : PAU_DR;
            PAU_DR:  state_next = TMS ? EX2_DR : PAU_DR;
            EX2_DR:  state_next = TMS ? UPD_DR : SH_DR;
            UPD_DR:  state_next = TMS ? SEL_DR : RTI;
            SEL_IR:  state_next = TMS ? TLR    : CAP_IR;
            CAP_IR:  state_next = TMS ? EX1_IR : SH_IR;
            SH_IR:   state_next = TMS ? EX1_IR : SH_IR;
            EX1_IR:  state_next = TMS ? UPD_IR : PAU_IR;
            PAU_IR:  state_next = TMS ? EX2_IR : PAU_IR;
            EX2_IR:  state_next = TMS ? UPD_IR : SH_IR;
            UPD_IR:  state_next = TMS ? SEL_DR : RTI;
            default: state_next = TLR;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) state <= TLR;
        else       state <= state_next;
    end

    // Instruction decode; an all-ones opcode is always BYPASS.
    always_comb begin
        sel_idcode = (ir == IDCODE_IR) && (ir != IR_ONES);
        user_sel_c = '0;
        for (int k = 0; k < NUM_USER; k++) begin
            if (!sel_idcode && (ir == IR_WIDTH'(USER_BASE + k)))
                user_sel_c[k] = 1'b1;
        end
        sel_user   = |user_sel_c;
        sel_bypass = !sel_idcode && !sel_user;
    end

    // Reload on the edge that enters TLR, so ir is valid as soon as TLR is.
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST)                    ir <= IDCODE_IR;
        else if (state_next == TLR)   ir <= IDCODE_IR;
        else if (state == UPD_IR)     ir <= ir_sr;
    end

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST)                ir_sr <= IR_CAPTURE;
        else if (state == CAP_IR) ir_sr <= IR_CAPTURE;
        else if (state == SH_IR)  ir_sr <= {TDI, ir_sr[IR_WIDTH-1:1]};
    end

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            bypass_reg <= 1'b0;
            idcode_sr  <= IDCODE_VAL;
        end else begin
            if (sel_bypass && state == CAP_DR) bypass_reg <= 1'b0;
            if (sel_bypass && state == SH_DR)  bypass_reg <= TDI;
            if (sel_idcode && state == CAP_DR) idcode_sr  <= IDCODE_VAL;
            if (sel_idcode && state == SH_DR)  idcode_sr  <= {TDI, idcode_sr[31:1]};
        end
    end

    // user_sel is one-hot, so masking and OR-reducing acts as the chain mux.
    always_comb begin
        dr_tdo = bypass_reg;
        if (sel_user)        dr_tdo = |(user_tdo & user_sel_c);
        else if (sel_idcode) dr_tdo = idcode_sr[0];
    end

    always_ff @(negedge TCK or negedge TRST) begin
        if (!TRST) begin
            TDO    <= 1'b0;
            TDO_EN <= 1'b0;
        end else begin
            case (state)
                SH_IR: begin
                    TDO    <= ir_sr[0];
                    TDO_EN <= 1'b1;
                end
                SH_DR: begin
                    TDO    <= dr_tdo;
                    TDO_EN <= 1'b1;
                end
                default: begin
                    TDO    <= 1'b0;
                    TDO_EN <= 1'b0;
                end
            endcase
        end
    end

    assign state_out        = state;
    assign ir_out           = ir;
    assign user_sel         = user_sel_c;
    assign test_logic_reset = (state == TLR);
    assign capture_dr       = (state == CAP_DR) && sel_user;
    assign shift_dr         = (state == SH_DR)  && sel_user;
    assign update_dr        = (state == UPD_DR) && sel_user;

endmodule

// File: tb/tb_jtag_tap_core.sv
// Self-checking bench for jtag_tap_core: table-driven walk of the TAP states,
// then scoreboarded IR/DR scans, pause/resume and abort sequences.
module tb_jtag_tap_core;

    localparam logic [31:0] IDV = 32'h1234_5679;
    localparam int M_IDCODE = 0;
    localparam int M_BYPASS = 1;
    localparam int M_USER   = 2;

    logic       TCK, TRST, TMS, TDI;
    logic       TDO, TDO_EN;
    logic [3:0] state_out, ir_out;
    logic       test_logic_reset, capture_dr, shift_dr, update_dr;
    logic [1:0] user_sel, user_tdo;

    int errors = 0;
    int checks = 0;
    int cap_n, sh_n, upd_n, en_n;
    logic exp_q[$];

    typedef struct {
        logic       tms;
        logic [3:0] st;
        logic       en;
        logic       tdo;
    } vec_t;
    vec_t tbl[22];

    jtag_tap_core dut (
        .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI),
        .TDO(TDO), .TDO_EN(TDO_EN),
        .state_out(state_out), .ir_out(ir_out),
        .test_logic_reset(test_logic_reset),
        .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
        .user_sel(user_sel), .user_tdo(user_tdo)
    );

    initial TCK = 1'b0;
    always #5 TCK = ~TCK;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic tick(input logic tms, input logic tdi);
        TMS = tms;
        TDI = tdi;
        @(posedge TCK);
        @(negedge TCK);
        #1;
    endtask

    task automatic step(input logic tms, input logic tdi, input logic exp_tdo);
        logic e;
        exp_q.push_back(exp_tdo);
        tick(tms, tdi);
        e = exp_q.pop_front();
        check("tdo", TDO, e);
        cap_n += capture_dr;
        sh_n  += shift_dr;
        upd_n += update_dr;
        en_n  += TDO_EN;
    endtask

    task automatic load_ir(input logic [3:0] v);
        logic [3:0] m;
        step(1, 0, 0);
        step(1, 0, 0);
        step(0, 0, 0);
        m = 4'b0001;
        step(0, 0, m[0]);
        for (int i = 0; i < 4; i++) begin
            m = {v[i], m[3:1]};
            step(i == 3, v[i], (i == 3) ? 1'b0 : m[0]);
        end
        step(1, 0, 0);
        step(0, 0, 0);
        check("ir_after_load", ir_out, v);
    endtask

    task automatic shift_dr_seq(input int n, input logic [31:0] tdi_v, input logic [31:0] pat,
                                input int mode, input int strobes);
        logic [31:0] mdl;
        logic        e;
        cap_n = 0; sh_n = 0; upd_n = 0; en_n = 0;
        step(1, 0, 0);
        step(0, 0, 0);
        mdl = (mode == M_IDCODE) ? IDV : 32'h0;
        if (mode == M_USER) user_tdo = {pat[0], ~pat[0]};
        e = (mode == M_USER) ? pat[0] : mdl[0];
        step(0, 0, e);
        for (int i = 0; i < n; i++) begin
            if (mode == M_IDCODE)      mdl = {tdi_v[i], mdl[31:1]};
            else if (mode == M_BYPASS) mdl[0] = tdi_v[i];
            if (i == n - 1)            e = 1'b0;
            else if (mode == M_USER) begin
                user_tdo = {pat[i+1], ~pat[i+1]};
                e = pat[i+1];
            end else                   e = mdl[0];
            step(i == n - 1, tdi_v[i], e);
        end
        user_tdo = 2'b00;
        step(1, 0, 0);
        step(0, 0, 0);
        check("capture_dr_count", cap_n, strobes);
        check("shift_dr_count",   sh_n,  (strobes != 0) ? n : 0);
        check("update_dr_count",  upd_n, strobes);
        check("tdo_en_count",     en_n,  n);
        check("state_after_dr",   state_out, 4'h1);
    endtask

    initial begin
        tbl[0]  = '{1, 4'h2, 0, 0}; tbl[1]  = '{0, 4'h3, 0, 0};
        tbl[2]  = '{0, 4'h4, 1, 1}; tbl[3]  = '{1, 4'h5, 0, 0};
        tbl[4]  = '{0, 4'h6, 0, 0}; tbl[5]  = '{1, 4'h7, 0, 0};
        tbl[6]  = '{0, 4'h4, 1, 0}; tbl[7]  = '{1, 4'h5, 0, 0};
        tbl[8]  = '{1, 4'h8, 0, 0}; tbl[9]  = '{1, 4'h2, 0, 0};
        tbl[10] = '{1, 4'h9, 0, 0}; tbl[11] = '{0, 4'hA, 0, 0};
        tbl[12] = '{0, 4'hB, 1, 1}; tbl[13] = '{1, 4'hC, 0, 0};
        tbl[14] = '{0, 4'hD, 0, 0}; tbl[15] = '{1, 4'hE, 0, 0};
        tbl[16] = '{1, 4'hF, 0, 0}; tbl[17] = '{0, 4'h1, 0, 0};
        tbl[18] = '{1, 4'h2, 0, 0}; tbl[19] = '{1, 4'h9, 0, 0};
        tbl[20] = '{1, 4'h0, 0, 0}; tbl[21] = '{1, 4'h0, 0, 0};

        TRST = 1'b1; TMS = 1'b1; TDI = 1'b0; user_tdo = 2'b00;
        #1 TRST = 1'b0;
        #2;
        check("rst_state",  state_out, 4'h0);
        check("rst_ir",     ir_out, 4'h1);
        check("rst_tdo",    TDO, 0);
        check("rst_tdo_en", TDO_EN, 0);
        check("rst_tlr",    test_logic_reset, 1);
        @(negedge TCK);
        #1 TRST = 1'b1;

        tick(0, 0);
        check("init_state",    state_out, 4'h1);
        check("init_ir",       ir_out, 4'h1);
        check("init_tdo_en",   TDO_EN, 0);
        check("init_user_sel", user_sel, 2'b00);

        foreach (tbl[i]) begin
            tick(tbl[i].tms, 1'b0);
            check("walk_state",  state_out, tbl[i].st);
            check("walk_tdo_en", TDO_EN, tbl[i].en);
            check("walk_tdo",    TDO, tbl[i].tdo);
        end
        check("walk_tlr_ir", ir_out, 4'h1);
        tick(0, 0);

        // IDCODE scan, no user strobes with IR=IDCODE.
        shift_dr_seq(32, 32'h0, 32'h0, M_IDCODE, 0);

        // BYPASS: one bit of delay.
        load_ir(4'hF);
        shift_dr_seq(8, 32'hA5, 32'h0, M_BYPASS, 0);

        // User chain 1.
        load_ir(4'h9);
        check("user_sel_9", user_sel, 2'b10);
        shift_dr_seq(8, 32'h0, 32'hB2, M_USER, 1);

        // IR scan with a pause in the middle.
        step(1, 0, 0);
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 1);
        step(0, 1, 0);
        step(1, 1, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        check("pause_state", state_out, 4'hD);
        check("pause_ir",    ir_out, 4'h9);
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 1, 0);
        step(1, 1, 0);
        step(1, 0, 0);
        step(0, 0, 0);
        check("resume_ir", ir_out, 4'hF);
        check("resume_user_sel", user_sel, 2'b00);

        // Escape mid-SH_DR with five TMS=1 clocks.
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 1, 1);
        step(0, 1, 1);
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        check("esc_state", state_out, 4'h0);
        check("esc_ir",    ir_out, 4'h1);
        check("esc_tlr",   test_logic_reset, 1);
        step(0, 0, 0);

        // TRST pulse mid-SH_DR.
        load_ir(4'hF);
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 1, 1);
        step(0, 1, 1);
        check("pre_abort_en", TDO_EN, 1);
        #2 TRST = 1'b0;
        #1;
        check("abort_state",  state_out, 4'h0);
        check("abort_ir",     ir_out, 4'h1);
        check("abort_tdo",    TDO, 0);
        check("abort_tdo_en", TDO_EN, 0);
        @(negedge TCK);
        #1 TRST = 1'b1;
        tick(0, 0);
        check("post_abort_state", state_out, 4'h1);
        shift_dr_seq(32, 32'hFFFF_0000, 32'h0, M_IDCODE, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
